alu_rr_scheduler: RTL and testbench

//  Shares one combinational WIDTH-bit ALU (3-bit control, ops 0..4, 2*WIDTH result) between two requesters.

---
 rtl/alu_rr_scheduler.sv | 165 ++++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one combinational ALU between two requesters.
// Round-robin arbitration picks one request in IDLE, the operands and control
// are registered towards the ALU, the result is captured one cycle later and
// presented on the granted channel's response port until it is consumed.
// Illegal opcodes (> MAX_OP) leave the ALU inputs untouched and return data 0
// with the error flag set, with the same latency as legal ops.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req{0,1}_valid/ready/op/a/b      request handshake and payload (ready is comb)
//   rsp{0,1}_valid/ready/data/err    response handshake, result and error flag
//   alu_control, alu_in_data1/2      registered ALU control and operands
//   alu_out_data                     ALU result (combinational from alu_*)
//   busy                             high whenever the scheduler is not IDLE
module alu_rr_scheduler #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned MAX_OP = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [2:0]         req0_op,
   input  logic [WIDTH-1:0]   req0_a,
   input  logic [WIDTH-1:0]   req0_b,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [2:0]         req1_op,
   input  logic [WIDTH-1:0]   req1_a,
   input  logic [WIDTH-1:0]   req1_b,
   output logic               rsp0_valid,
   input  logic               rsp0_ready,
   output logic [2*WIDTH-1:0] rsp0_data,
   output logic               rsp0_err,
   output logic               rsp1_valid,
   input  logic               rsp1_ready,
   output logic [2*WIDTH-1:0] rsp1_data,
   output logic               rsp1_err,
   output logic [2:0]         alu_control,
   output logic [WIDTH-1:0]   alu_in_data1,
   output logic [WIDTH-1:0]   alu_in_data2,
   input  logic [2*WIDTH-1:0] alu_out_data,
   output logic               busy
);

   localparam int unsigned RW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t            state, state_nx;
   logic              last_grant;
   logic              ch;
   logic              err;

   logic              any_valid;
   logic              sel;
   logic              hs;
   logic [2:0]        hs_op;
   logic [WIDTH-1:0]  hs_a;
   logic [WIDTH-1:0]  hs_b;
   logic              hs_err;
   logic              rel;

   logic              do_load;
   logic              do_load_alu;
   logic              do_capture;
   logic              do_release;
   logic [RW-1:0]     result;

   // Arbitration: on a tie the channel that did not win last time goes next.
   assign any_valid  = req0_valid | req1_valid;
   assign sel        = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
   assign req0_ready = (state == IDLE) & any_valid & ~sel;
   assign req1_ready = (state == IDLE) & any_valid & sel;
   assign hs         = req0_ready | req1_ready;

   assign hs_op  = sel ? req1_op : req0_op;
   assign hs_a   = sel ? req1_a  : req0_a;
   assign hs_b   = sel ? req1_b  : req0_b;
   assign hs_err = 32'(hs_op) > MAX_OP;

   assign rel    = (state == RESP) & (ch ? rsp1_ready : rsp0_ready);
   assign result = err ? RW'(0) : alu_out_data;
   assign busy   = (state != IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (hs)  state_nx = EXEC;
         EXEC:             state_nx = RESP;
         RESP:    if (rel) state_nx = IDLE;
         default:          state_nx = IDLE;
      endcase
   end

   // Datapath enables derived from the current state.
   always_comb begin
      do_load     = 1'b0;
      do_load_alu = 1'b0;
      do_capture  = 1'b0;
      do_release  = 1'b0;
      case (state)
         IDLE: begin
            do_load     = hs;
            do_load_alu = hs & ~hs_err;
         end
         EXEC:    do_capture = 1'b1;
         RESP:    do_release = rel;
         default: ;
      endcase
   end

   // Registered datapath: grant bookkeeping, ALU inputs and response ports.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant   <= 1'b1;
         ch           <= 1'b0;
         err          <= 1'b0;
         alu_control  <= 3'd0;
         alu_in_data1 <= WIDTH'(0);
         alu_in_data2 <= WIDTH'(0);
         rsp0_valid   <= 1'b0;
         rsp0_data    <= RW'(0);
         rsp0_err     <= 1'b0;
         rsp1_valid   <= 1'b0;
         rsp1_data    <= RW'(0);
         rsp1_err     <= 1'b0;
      end else begin
         if (do_load) begin
            ch         <= sel;
            last_grant <= sel;
            err        <= hs_err;
         end
         if (do_load_alu) begin
            alu_control  <= hs_op;
            alu_in_data1 <= hs_a;
            alu_in_data2 <= hs_b;
         end
         if (do_capture) begin
            if (ch) begin
               rsp1_valid <= 1'b1;
               rsp1_data  <= result;
               rsp1_err   <= err;
            end else begin
               rsp0_valid <= 1'b1;
               rsp0_data  <= result;
               rsp0_err   <= err;
            end
         end
         // Data and error flag keep their last values after valid drops.
         if (do_release) begin
            if (ch) rsp1_valid <= 1'b0;
            else    rsp0_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Testbench for alu_rr_scheduler: stub ALU returns {in1, in2}. A negedge
// monitor predicts arbitration from a behavioural model, pushes the expected
// response on each predicted handshake and pops/compares on each response.
module tb_alu_rr_scheduler;

   localparam int unsigned WIDTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [2:0] req0_op, req1_op;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic       rsp0_valid, rsp0_ready, rsp0_err;
   logic       rsp1_valid, rsp1_ready, rsp1_err;
   logic [7:0] rsp0_data, rsp1_data;
   logic [2:0] alu_control;
   logic [3:0] alu_in_data1, alu_in_data2;
   logic [7:0] alu_out_data;
   logic       busy;

   always #5 clk = ~clk;

   assign alu_out_data = {alu_in_data1, alu_in_data2};

   alu_rr_scheduler #(.WIDTH(WIDTH), .MAX_OP(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
      .rsp1_err(rsp1_err),
      .alu_control(alu_control), .alu_in_data1(alu_in_data1),
      .alu_in_data2(alu_in_data2), .alu_out_data(alu_out_data), .busy(busy)
   );

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         hs_cyc;
   } exp_t;

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   bit   mon_en = 1'b0;

   // Behavioural model: who won last, whether an op is outstanding, and what
   // the ALU inputs should hold.
   bit         m_last;
   int         m_out;
   logic [2:0] m_ctl;
   logic [3:0] m_a, m_b;
   exp_t       q0[$], q1[$];
   bit         pv[2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      q0.delete();
      q1.delete();
      m_out  = 0;
      m_last = 1'b1;
      m_ctl  = 3'd0;
      m_a    = 4'd0;
      m_b    = 4'd0;
      pv[0]  = 1'b0;
      pv[1]  = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rsp0_valid"}, 32'(rsp0_valid), 0);
      check({tag, "_rsp1_valid"}, 32'(rsp1_valid), 0);
      check({tag, "_rsp0_data"},  32'(rsp0_data),  0);
      check({tag, "_rsp1_data"},  32'(rsp1_data),  0);
      check({tag, "_rsp0_err"},   32'(rsp0_err),   0);
      check({tag, "_rsp1_err"},   32'(rsp1_err),   0);
      check({tag, "_alu_ctl"},    32'(alu_control), 0);
      check({tag, "_alu_in1"},    32'(alu_in_data1), 0);
      check({tag, "_alu_in2"},    32'(alu_in_data2), 0);
      check({tag, "_busy"},       32'(busy), 0);
   endtask

   // Holds reset for n edges starting now, then checks the reset state.
   task automatic do_reset(input int n);
      mon_en     = 1'b0;
      rst        = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (n) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      model_clear();
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
   endtask

   // Presents one request and waits (bounded) until it is accepted.
   task automatic send(input bit ch, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b);
      bit got = 1'b0;
      if (ch) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
      else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         got = ch ? req1_ready : req0_ready;
      end
      check("send_accepted", 32'(got), 1);
      @(posedge clk);
      #1;
      if (ch) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
   endtask

   // Monitor: arbitration/ALU/busy prediction and response scoreboard.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         bit   v0, v1, idle, sel1, e0, e1;
         v0   = req0_valid;
         v1   = req1_valid;
         idle = (m_out == 0);
         sel1 = (v0 && v1) ? !m_last : v1;
         e0   = idle && (v0 || v1) && !sel1;
         e1   = idle && (v0 || v1) && sel1;
         check("req0_ready", 32'(req0_ready), 32'(e0));
         check("req1_ready", 32'(req1_ready), 32'(e1));
         check("busy", 32'(busy), 32'(!idle));
         check("alu_control", 32'(alu_control), 32'(m_ctl));
         check("alu_in1", 32'(alu_in_data1), 32'(m_a));
         check("alu_in2", 32'(alu_in_data2), 32'(m_b));

         for (int c = 0; c < 2; c++) begin
            logic       rv, rr, re;
            logic [7:0] rd;
            int         qn;
            exp_t       ex;
            rv = c ? rsp1_valid : rsp0_valid;
            rr = c ? rsp1_ready : rsp0_ready;
            rd = c ? rsp1_data  : rsp0_data;
            re = c ? rsp1_err   : rsp0_err;
            qn = c ? q1.size() : q0.size();
            if (qn == 0) begin
               check(c ? "rsp1_unexpected" : "rsp0_unexpected", 32'(rv), 0);
            end else if (rv) begin
               ex = c ? q1[0] : q0[0];
               check(c ? "rsp1_data" : "rsp0_data", 32'(rd), 32'(ex.data));
               check(c ? "rsp1_err" : "rsp0_err", 32'(re), 32'(ex.err));
               if (!pv[c])
                  check(c ? "rsp1_latency" : "rsp0_latency", 32'(cyc - ex.hs_cyc), 2);
               if (rr) begin
                  if (c) void'(q1.pop_front());
                  else   void'(q0.pop_front());
                  m_out = 0;
               end
            end
            pv[c] = rv && !rr;
         end

         if (e0 || e1) begin
            exp_t       ex;
            logic [2:0] op;
            op        = e1 ? req1_op : req0_op;
            ex.err    = (op > 3'd4);
            ex.hs_cyc = cyc;
            if (!ex.err) begin
               m_ctl = op;
               m_a   = e1 ? req1_a : req0_a;
               m_b   = e1 ? req1_b : req0_b;
            end
            ex.data = ex.err ? 8'h00 : {m_a, m_b};
            if (e1) q1.push_back(ex);
            else    q0.push_back(ex);
            m_last = e1;
            m_out  = 1;
         end
      end
   end

   initial begin
      rst        = 1'b1;
      req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      model_clear();

      // Reset, then a single ch0 op=0 3,5 -> 8'h35.
      do_reset(2);
      send(1'b0, 3'd0, 4'h3, 4'h5);
      repeat (4) @(posedge clk);

      // Both channels competing; ch1 op=2 F,1 -> 8'hF1; then illegal op on ch1.
      #1;
      req0_valid = 1'b1; req0_op = 3'd1; req0_a = 4'h2; req0_b = 4'h4;
      req1_valid = 1'b1; req1_op = 3'd2; req1_a = 4'hF; req1_b = 4'h1;
      repeat (12) @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_op = 3'd5; req1_a = 4'h7; req1_b = 4'h7;
      repeat (6) @(posedge clk);
      #1;
      req1_valid = 1'b0;
      repeat (4) @(posedge clk);

      // Response back-pressure held for several cycles.
      #1;
      rsp0_ready = 1'b0;
      send(1'b0, 3'd3, 4'hA, 4'h6);
      repeat (7) @(posedge clk);
      #1;
      rsp0_ready = 1'b1;
      repeat (4) @(posedge clk);

      // Randomized traffic with random back-pressure.
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         req0_valid = ($urandom_range(0, 9) < 6);
         req1_valid = ($urandom_range(0, 9) < 6);
         req0_op    = 3'($urandom_range(0, 7));
         req1_op    = 3'($urandom_range(0, 7));
         req0_a     = 4'($urandom);
         req0_b     = 4'($urandom);
         req1_a     = 4'($urandom);
         req1_b     = 4'($urandom);
         rsp0_ready = ($urandom_range(0, 9) < 7);
         rsp1_ready = ($urandom_range(0, 9) < 7);
      end
      @(posedge clk);
      #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      // Reset during EXEC drops the op; the monitor flags any response.
      send(1'b1, 3'd1, 4'h9, 4'h3);
      do_reset(1);
      repeat (15) @(posedge clk);

      @(negedge clk);
      check("drain_q0", 32'(q0.size()), 0);
      check("drain_q1", 32'(q1.size()), 0);
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
